// File: rtl/duty_ramp_ctrl.sv
// Switch-to-duty front end for the LED PWM: sync, debounce, then slew
// the duty toward the debounced target one step per STEP_DIV periods.
module duty_ramp_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP            = 1,
  parameter int STEP_DIV        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] switches,
  input  logic       period_end,
  output logic [7:0] duty,
  output logic [7:0] target,
  output logic       busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(STEP_DIV - 1);
  localparam logic [8:0]    STEP9   = 9'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } state_t;

  logic [7:0]    s1;
  logic [7:0]    s2;
  logic [7:0]    cand;
  logic [CW-1:0] cnt;
  logic [DW-1:0] div;
  state_t        state;
  state_t        state_nxt;
  logic          step_fire;
  logic [8:0]    up_sum;
  logic [7:0]    up_val;
  logic signed [8:0] dn_diff;
  logic [7:0]    dn_val;
  logic [7:0]    duty_nxt;

  // Two-flop synchronizer for the asynchronous switch levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= switches;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand   <= '0;
      cnt    <= '0;
      target <= '0;
    end else if (s2 != cand) begin
      cand <= s2;
      cnt  <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end else begin
      target <= cand;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    unique case (1'b1)
      (target > duty): state_nxt = RAMP_UP;
      (target < duty): state_nxt = RAMP_DOWN;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign busy      = (state != IDLE);
  assign step_fire = period_end && busy && (div == DIV_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (!busy) begin
      div <= '0;
    end else if (period_end) begin
      div <= (div == DIV_MAX) ? '0 : div + DW'(1);
    end
  end

  // Wide arithmetic so a step clamps at target instead of wrapping.
  assign up_sum  = {1'b0, duty} + STEP9;
  assign up_val  = (up_sum > {1'b0, target}) ? target : up_sum[7:0];
  assign dn_diff = $signed({1'b0, duty}) - $signed(STEP9);
  assign dn_val  = (dn_diff < $signed({1'b0, target}))
                 ? target : dn_diff[7:0];

  always_comb begin
    duty_nxt = duty;
    if (step_fire) begin
      unique case (state)
        RAMP_UP:   duty_nxt = up_val;
        RAMP_DOWN: duty_nxt = dn_val;
        default:   duty_nxt = duty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= '0;
    end else begin
      duty <= duty_nxt;
    end
  end

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Bench for duty_ramp_ctrl: a default instance and a STEP=5/STEP_DIV=3
// instance, driven from a vector table plus hand-written ramp sequences.
module tb_duty_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw_a, sw_b;
  logic       pe_a, pe_b;
  logic [7:0] duty_a, duty_b, target_a, target_b;
  logic       busy_a, busy_b;

  int n_cmp = 0;
  int n_bad = 0;
  int hold_bad = 0;

  typedef struct {
    string      name;
    bit         b;
    logic [7:0] d;
    logic [7:0] t;
    logic       bz;
  } exp_t;

  typedef struct {
    string      name;
    bit         b;
    logic [7:0] sw;
    int         wait_n;
    int         pulses;
    logic [7:0] d;
    logic [7:0] t;
    logic       bz;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];

  always #5 clk = ~clk;

  duty_ramp_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .switches(sw_a), .period_end(pe_a),
    .duty(duty_a), .target(target_a), .busy(busy_a)
  );

  duty_ramp_ctrl #(
    .DEBOUNCE_CYCLES(4), .STEP(5), .STEP_DIV(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .switches(sw_b), .period_end(pe_b),
    .duty(duty_b), .target(target_b), .busy(busy_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input bit b, input int d,
                      input int t, input bit bz);
    exp_t e;
    e.name = name;
    e.b = b;
    e.d = 8'(d);
    e.t = 8'(t);
    e.bz = bz;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".duty"}, e.b ? duty_b : duty_a, e.d);
    chk({e.name, ".target"}, e.b ? target_b : target_a, e.t);
    chk({e.name, ".busy"}, e.b ? busy_b : busy_a, e.bz);
  endtask

  task automatic pe_pulse(input bit b, input int gap);
    logic [7:0] d0;
    d0 = b ? duty_b : duty_a;
    repeat (gap - 1) begin
      tick();
      if ((b ? duty_b : duty_a) != d0) hold_bad++;
    end
    if (b) pe_b = 1'b1;
    else pe_a = 1'b1;
    tick();
    pe_a = 1'b0;
    pe_b = 1'b0;
  endtask

  task automatic ramp_a(input string name, input int n, input int gap,
                        input int d0, input int dir, input int tgt);
    for (int i = 1; i <= n; i++) begin
      push(name, 1'b0, d0 + dir * i, tgt, 1'b1);
      pe_pulse(1'b0, gap);
      pop_cmp();
    end
  endtask

  task automatic add_vec(input string name, input bit b, input int sw,
                         input int wait_n, input int pulses, input int d,
                         input int t, input bit bz);
    vec_t v;
    v.name = name;
    v.b = b;
    v.sw = 8'(sw);
    v.wait_n = wait_n;
    v.pulses = pulses;
    v.d = 8'(d);
    v.t = 8'(t);
    v.bz = bz;
    vt.push_back(v);
  endtask

  initial begin
    int nz;
    add_vec("db_pre", 0, 128, 18, 0, 0, 0, 0);
    add_vec("db_e19", 0, 128, 1, 0, 0, 128, 0);
    add_vec("db_busy", 0, 128, 1, 0, 0, 128, 1);
    add_vec("glitch", 0, 8'h55, 10, 0, 0, 128, 1);
    add_vec("glitch_after", 0, 128, 30, 0, 0, 128, 1);
    add_vec("b_tgt12", 1, 12, 7, 0, 0, 12, 0);
    add_vec("b_up", 1, 12, 1, 0, 0, 12, 1);
    add_vec("b_div1", 1, 12, 0, 1, 0, 12, 1);
    add_vec("b_div2", 1, 12, 0, 1, 0, 12, 1);
    add_vec("b_step5", 1, 12, 0, 1, 5, 12, 1);
    add_vec("b_step10", 1, 12, 0, 3, 10, 12, 1);
    add_vec("b_div_10", 1, 12, 0, 2, 10, 12, 1);
    add_vec("b_sat12", 1, 12, 0, 1, 12, 12, 1);
    add_vec("b_idle", 1, 12, 1, 0, 12, 12, 0);
    add_vec("b_idle_pe", 1, 12, 0, 2, 12, 12, 0);
    add_vec("b_tgt3", 1, 3, 7, 0, 12, 3, 0);
    add_vec("b_down", 1, 3, 1, 0, 12, 3, 1);
    add_vec("b_first2", 1, 3, 0, 2, 12, 3, 1);
    add_vec("b_dn7", 1, 3, 0, 1, 7, 3, 1);
    add_vec("b_dn3", 1, 3, 0, 3, 3, 3, 1);
    add_vec("b_idle3", 1, 3, 1, 0, 3, 3, 0);
    add_vec("b_tgt0", 1, 0, 7, 0, 3, 0, 0);
    add_vec("b_down0", 1, 0, 1, 0, 3, 0, 1);
    add_vec("b_floor", 1, 0, 0, 3, 0, 0, 1);
    add_vec("b_idle0", 1, 0, 1, 0, 0, 0, 0);
    add_vec("b_nowrap", 1, 0, 0, 6, 0, 0, 0);

    rst_n = 1'b1;
    sw_a = 8'hFF;
    sw_b = 8'hFF;
    pe_a = 1'b0;
    pe_b = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    push("rst_async", 0, 0, 0, 0);
    pop_cmp();
    push("rst_async_b", 1, 0, 0, 0);
    pop_cmp();
    repeat (3) tick();
    sw_a = 8'h00;
    sw_b = 8'h00;
    tick();
    rst_n = 1'b1;
    nz = 0;
    repeat (1000) begin
      tick();
      if (duty_a != 0 || target_a != 0 || busy_a) nz++;
      if (duty_b != 0 || target_b != 0 || busy_b) nz++;
    end
    chk("idle1000", nz, 0);

    foreach (vt[i]) begin
      if (vt[i].b) sw_b = vt[i].sw;
      else sw_a = vt[i].sw;
      repeat (vt[i].wait_n) tick();
      repeat (vt[i].pulses) pe_pulse(vt[i].b, 4);
      push(vt[i].name, vt[i].b, vt[i].d, vt[i].t, vt[i].bz);
      pop_cmp();
    end

    ramp_a("ramp_up", 128, 256, 0, 1, 128);
    tick();
    push("ramp_done", 0, 128, 128, 0);
    pop_cmp();
    repeat (3) pe_pulse(1'b0, 16);
    push("ramp_hold", 0, 128, 128, 0);
    pop_cmp();

    sw_a = 8'd0;
    repeat (20) tick();
    push("dn_start", 0, 128, 0, 1);
    pop_cmp();
    ramp_a("ramp_dn", 51, 8, 128, -1, 0);
    rst_n = 1'b0;
    #1;
    push("rst_mid", 0, 0, 0, 0);
    pop_cmp();
    sw_a = 8'd50;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (18) tick();
    push("rel_e18", 0, 0, 0, 0);
    pop_cmp();
    tick();
    push("rel_e19", 0, 0, 50, 0);
    pop_cmp();
    tick();
    push("rel_busy", 0, 0, 50, 1);
    pop_cmp();
    ramp_a("ramp50", 50, 8, 0, 1, 50);
    tick();
    push("ramp50_done", 0, 50, 50, 0);
    pop_cmp();

    sw_a = 8'd200;
    repeat (20) tick();
    ramp_a("rev_up", 10, 8, 50, 1, 200);
    sw_a = 8'd10;
    repeat (20) tick();
    push("rev_tgt", 0, 60, 10, 1);
    pop_cmp();
    ramp_a("rev_dn", 50, 8, 60, -1, 10);
    tick();
    push("rev_done", 0, 10, 10, 0);
    pop_cmp();

    chk("hold_between_pe", hold_bad, 0);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
